// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder controller.
// Build option: SERIAL_ADDER_OVF_EN adds a signed-overflow output to serial_adder_ctrl.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/serial_adder_ctrl_full_adder_cell.sv
// Gate-level full adder: two half adders whose carries are merged by an OR gate.
// This is the only arithmetic in the serial adder; the controller reuses it every bit.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    xor g_sum   (sum, a, b);
    and g_carry (carry, a, b);

endmodule

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    logic w_s1;
    logic w_c1;
    logic w_c2;

    half_adder u_ha0 (.a(a),    .b(b),   .sum(w_s1), .carry(w_c1));
    half_adder u_ha1 (.a(w_s1), .b(cin), .sum(sum),  .carry(w_c2));

    or g_carry (carry, w_c1, w_c2);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell sequenced LSB first over WIDTH clocks.
// Build option: SERIAL_ADDER_OVF_EN adds output ovf (two's-complement overflow).
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_result;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;
    logic             w_sum;
    logic             w_carry;

    full_adder_cell u_fa (
        .a     (r_opa[0]),
        .b     (r_opb[0]),
        .cin   (r_carry),
        .sum   (w_sum),
        .carry (w_carry)
    );

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    // Next-state decode; start is only honoured in IDLE.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next   = RUN;
                    w_accept = 1'b1;
                end else begin
                    w_next   = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next = DONE;
                end else begin
                    w_next = RUN;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Handshake flags registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next == RUN);
            r_done <= (w_next == DONE);
        end
    end

    // Operand capture, per-bit shifting and result assembly (sum enters at the MSB).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opa    <= '0;
            r_opb    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
        end else if (w_accept) begin
            r_opa    <= a;
            r_opb    <= b;
            r_result <= '0;
            r_cnt    <= '0;
            r_carry  <= cin;
            r_cout   <= 1'b0;
        end else if (r_state == RUN) begin
            r_opa    <= {1'b0, r_opa[WIDTH-1:1]};
            r_opb    <= {1'b0, r_opb[WIDTH-1:1]};
            r_result <= {w_sum, r_result[WIDTH-1:1]};
            r_cnt    <= r_cnt + CW'(1);
            r_carry  <= w_carry;
            if (w_last) begin
                r_cout <= w_carry;
            end else begin
                r_cout <= r_cout;
            end
        end else begin
            r_opa    <= r_opa;
            r_opb    <= r_opb;
            r_result <= r_result;
            r_cnt    <= r_cnt;
            r_carry  <= r_carry;
            r_cout   <= r_cout;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // Signed overflow: carry into the MSB differs from the carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= 1'b0;
        end else if ((r_state == RUN) && w_last) begin
            r_ovf <= r_carry ^ w_carry;
        end else begin
            r_ovf <= r_ovf;
        end
    end

    assign ovf = r_ovf;
`endif

    assign result = r_result;
    assign cout   = r_cout;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8).
// Build option: SERIAL_ADDER_OVF_EN also exercises the ovf output.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] result;
    logic         cout;
    logic         busy;
    logic         done;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int n_checks;
    int n_errors;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .result (result),
        .cout   (cout),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf    (ovf),
`endif
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request in IDLE; returns 1ns after the accepting edge.
    task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
        @(negedge clk);
        a     = va;
        b     = vb;
        cin   = vc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Advance until done rises (bounded), measuring elapsed edges and busy cycles.
    task automatic wait_done(output int cycles, output int busy_cnt, output int overlap);
        cycles   = 0;
        busy_cnt = 0;
        overlap  = 0;
        while (done !== 1'b1 && cycles < 40) begin
            if (busy === 1'b1) busy_cnt++;
            @(posedge clk);
            #1;
            cycles++;
            if (busy === 1'b1 && done === 1'b1) overlap++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        #12;
        n_checks++;
        if ({result, cout, busy, done} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
            $display("FAIL reset_outputs: got result=%h cout=%b busy=%b done=%b, want all zero",
                     result, cout, busy, done);
            n_errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
            n_errors++;
        end
    endtask

    task automatic test_basic_add;
        int cyc, bc, ov;
        launch(8'h35, 8'h4A, 1'b0);
        wait_done(cyc, bc, ov);
        n_checks++;
        if (cyc !== W) begin
            $display("FAIL basic_latency: got %0d edges after start, want %0d", cyc, W);
            n_errors++;
        end
        n_checks++;
        if (bc !== W || ov !== 0) begin
            $display("FAIL basic_busy: got busy cycles %0d overlap %0d, want %0d 0", bc, ov, W);
            n_errors++;
        end
        n_checks++;
        if (result !== 8'h7F || cout !== 1'b0) begin
            $display("FAIL basic_sum: got %h/%b, want 7f/0", result, cout);
            n_errors++;
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== 8'h7F) begin
            $display("FAIL basic_hold: got done=%b busy=%b result=%h, want 0 0 7f", done, busy, result);
            n_errors++;
        end
    endtask

    task automatic test_carry;
        int cyc, bc, ov;
        launch(8'hFF, 8'h01, 1'b0);
        wait_done(cyc, bc, ov);
        n_checks++;
        if (result !== 8'h00 || cout !== 1'b1 || cyc !== W) begin
            $display("FAIL carry_wrap: got %h/%b in %0d, want 00/1 in %0d", result, cout, cyc, W);
            n_errors++;
        end
        @(posedge clk);
        #1;
        launch(8'h00, 8'h00, 1'b1);
        n_checks++;
        if (result !== 8'h00 || cout !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL carry_clear_on_start: got %h/%b busy=%b, want 00/0 busy=1", result, cout, busy);
            n_errors++;
        end
        wait_done(cyc, bc, ov);
        n_checks++;
        if (result !== 8'h01 || cout !== 1'b0) begin
            $display("FAIL carry_in: got %h/%b, want 01/0", result, cout);
            n_errors++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_start_ignored;
        int cyc, bc, ov, nd;
        launch(8'h10, 8'h20, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        a     = 8'hFF;
        b     = 8'hFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc, bc, ov);
        n_checks++;
        if (result !== 8'h30 || cout !== 1'b0 || cyc !== W - 3) begin
            $display("FAIL ignore_sum: got %h/%b in %0d, want 30/0 in %0d", result, cout, cyc, W - 3);
            n_errors++;
        end
        nd = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) nd++;
        end
        n_checks++;
        if (nd !== 0 || result !== 8'h30) begin
            $display("FAIL ignore_no_second_op: got %0d active cycles result=%h, want 0 30", nd, result);
            n_errors++;
        end
    endtask

    task automatic test_reset_mid_run;
        int cyc, bc, ov, nd;
        launch(8'h55, 8'h11, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({result, cout, busy, done} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
            $display("FAIL midrun_reset: got result=%h cout=%b busy=%b done=%b, want all zero",
                     result, cout, busy, done);
            n_errors++;
        end
        nd = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) nd++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) nd++;
        end
        n_checks++;
        if (nd !== 0) begin
            $display("FAIL midrun_no_done: got %0d done/busy cycles, want 0", nd);
            n_errors++;
        end
        launch(8'h03, 8'h04, 1'b0);
        wait_done(cyc, bc, ov);
        n_checks++;
        if (result !== 8'h07 || cout !== 1'b0 || cyc !== W) begin
            $display("FAIL midrun_recover: got %h/%b in %0d, want 07/0 in %0d", result, cout, cyc, W);
            n_errors++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] exp_r [3];
        logic         exp_c [3];
        int           exp_t [3];
        int           t, nd;
        exp_r[0] = 8'h33; exp_c[0] = 1'b0; exp_t[0] = 9;
        exp_r[1] = 8'h0B; exp_c[1] = 1'b0; exp_t[1] = 19;
        exp_r[2] = 8'h10; exp_c[2] = 1'b1; exp_t[2] = 29;
        @(negedge clk);
        a     = 8'h11;
        b     = 8'h22;
        cin   = 1'b0;
        start = 1'b1;
        t     = 0;
        nd    = 0;
        while (t < 30) begin
            @(posedge clk);
            #1;
            t++;
            if (t == 2) a = 8'hAA;
            if (done === 1'b1) begin
                if (nd < 3) begin
                    n_checks++;
                    if (result !== exp_r[nd] || cout !== exp_c[nd] || t !== exp_t[nd]) begin
                        $display("FAIL b2b_op%0d: got %h/%b at edge %0d, want %h/%b at edge %0d",
                                 nd, result, cout, t, exp_r[nd], exp_c[nd], exp_t[nd]);
                        n_errors++;
                    end
                end
                nd++;
                if (nd == 1) begin
                    a = 8'h05;
                    b = 8'h06;
                end else begin
                    a = 8'hF0;
                    b = 8'h20;
                end
            end
        end
        start = 1'b0;
        n_checks++;
        if (nd !== 3) begin
            $display("FAIL b2b_count: got %0d done pulses, want 3", nd);
            n_errors++;
        end
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    task automatic test_ovf;
        int cyc, bc, ov;
        launch(8'h7F, 8'h01, 1'b0);
        wait_done(cyc, bc, ov);
        n_checks++;
        if (result !== 8'h80 || cout !== 1'b0 || ovf !== 1'b1) begin
            $display("FAIL ovf_set: got %h/%b ovf=%b, want 80/0 ovf=1", result, cout, ovf);
            n_errors++;
        end
        @(posedge clk);
        #1;
        launch(8'hFF, 8'h01, 1'b0);
        n_checks++;
        if (ovf !== 1'b0) begin
            $display("FAIL ovf_clear_on_start: got %b, want 0", ovf);
            n_errors++;
        end
        wait_done(cyc, bc, ov);
        n_checks++;
        if (result !== 8'h00 || cout !== 1'b1 || ovf !== 1'b0) begin
            $display("FAIL ovf_unsigned_carry: got %h/%b ovf=%b, want 00/1 ovf=0", result, cout, ovf);
            n_errors++;
        end
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_basic_add();
        test_carry();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
`ifdef SERIAL_ADDER_OVF_EN
        test_ovf();
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
